load_store_unit: RTL and testbench

- Sits directly upstream of the word-addressed data memory (32-bit words, index-addressed, registered read, 1-cycle read latency, synchronous clear on rst).
- Accepts byte-addressed load/store requests from the execute stage.
- Checks alignment and range, then drives the memory strobes.
- Performs read-modify-write for byte/halfword stores, and returns zero- or sign-extended load data.

---
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory with registered reads.
// Checks requests, does read-modify-write for sub-word stores and extends load data.
//
// state | meaning
// IDLE  | ready; accept and classify a request
// RD    | memory read strobe for load or sub-word store
// CAP   | read data valid: extend load data or merge store lane
// WR    | memory write strobe
// RESP  | one-cycle completion pulse
module load_store_unit #(
  parameter int W = 32,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         resp_valid,
  output logic [W-1:0] resp_rdata,
  output logic [1:0]   resp_err,
  output logic [W-1:0] mem_address,
  output logic         MemRead,
  output logic         MemWrite,
  output logic [W-1:0] mem_write_data,
  input  logic [W-1:0] mem_read_data
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t       state, state_nxt;
  logic         write_q, unsigned_q;
  logic [1:0]   size_q;
  logic [N+1:0] addr_q;
  logic [15:0]  wdata_q;
  logic [W-1:0] merge_q;
  logic [1:0]   err;
  logic [7:0]   lane_b;
  logic [15:0]  lane_h;
  logic [W-1:0] load_ext, merged;

  assign mem_address    = {{(W-N){1'b0}}, addr_q[N+1:2]};
  assign mem_write_data = merge_q;

  // Priority: illegal size, then range, then alignment.
  always_comb begin
    err = 2'b00;
    if (req_size == 2'b11)
      err = 2'b11;
    else if (req_addr[W-1:N+2] != '0)
      err = 2'b10;
    else if ((req_size == 2'b01 && req_addr[0]) ||
             (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      err = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (err != 2'b00)                         state_nxt = RESP;
          else if (req_write && req_size == 2'b10)  state_nxt = WR;
          else                                      state_nxt = RD;
        end
      end
      RD: begin
        MemRead   = 1'b1;
        state_nxt = CAP;
      end
      CAP:  state_nxt = write_q ? WR : RESP;
      WR: begin
        MemWrite  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Little-endian lane select, extension and store merge.
  always_comb begin
    lane_b = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_read_data[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = unsigned_q ? {{(W-8){1'b0}}, lane_b}
                                     : {{(W-8){lane_b[7]}}, lane_b};
      2'b01:   load_ext = unsigned_q ? {{(W-16){1'b0}}, lane_h}
                                     : {{(W-16){lane_h[15]}}, lane_h};
      default: load_ext = mem_read_data;
    endcase
    merged = mem_read_data;
    if (size_q == 2'b00)
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_q    <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 2'b00;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          write_q    <= req_write;
          unsigned_q <= req_unsigned;
          size_q     <= req_size;
          addr_q     <= req_addr[N+1:0];
          wdata_q    <= req_wdata[15:0];
          merge_q    <= req_wdata;
          if (err != 2'b00) begin
            resp_err   <= err;
            resp_rdata <= '0;
          end
        end
        CAP: begin
          if (write_q) begin
            merge_q <= merged;
          end else begin
            resp_rdata <= load_ext;
            resp_err   <= 2'b00;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus random requests
// against a byte-array reference of memory contents.
module tb_load_store_unit;
  localparam int W = 32;
  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]   req_size;
  logic [W-1:0] req_addr, req_wdata;
  logic         resp_valid;
  logic [W-1:0] resp_rdata;
  logic [1:0]   resp_err;
  logic [W-1:0] mem_address;
  logic         MemRead, MemWrite;
  logic [W-1:0] mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_address(mem_address), .MemRead(MemRead),
    .MemWrite(MemWrite), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  // Data memory: word indexed, registered read, synchronous clear.
  logic [31:0] mem [0:31];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
      mem_read_data <= '0;
    end else begin
      if (MemWrite) mem[mem_address[4:0]] <= mem_write_data;
      if (MemRead)  mem_read_data <= mem[mem_address[4:0]];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [7:0] rmem [0:127];

  function automatic logic [31:0] rword(input int base);
    return {rmem[base+3], rmem[base+2], rmem[base+1], rmem[base]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 128; i++) rmem[i] = 8'h00;
  endtask

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit hold);
    logic [1:0]  e;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] rdata_exp, wdata_exp;
    int a, base, lat_exp, rd_exp, wr_exp;
    int lat, nrd, nwr, nboth, nready, nbadaddr, nbadw;

    e = 2'b00;
    if (sz == 2'd3) e = 2'b11;
    else if (addr[31:7] != 0) e = 2'b10;
    else if ((sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00)) e = 2'b01;

    a    = int'(addr[6:0]);
    base = (a / 4) * 4;
    rdata_exp = 0; wdata_exp = 0; rd_exp = 0; wr_exp = 0;
    if (e != 2'b00) begin
      lat_exp = 1;
    end else if (!wr) begin
      lat_exp = 3; rd_exp = 1;
      case (sz)
        2'd0: begin
          b = rmem[a];
          rdata_exp = uns ? {24'h0, b} : {{24{b[7]}}, b};
        end
        2'd1: begin
          h = {rmem[a+1], rmem[a]};
          rdata_exp = uns ? {16'h0, h} : {{16{h[15]}}, h};
        end
        default: rdata_exp = rword(base);
      endcase
    end else begin
      wr_exp = 1;
      if (sz == 2'd2) lat_exp = 2;
      else begin lat_exp = 4; rd_exp = 1; end
      rmem[a] = wd[7:0];
      if (sz != 2'd0) rmem[a+1] = wd[15:8];
      if (sz == 2'd2) begin rmem[a+2] = wd[23:16]; rmem[a+3] = wd[31:24]; end
      wdata_exp = rword(base);
    end

    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    check("ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!hold) req_valid = 1'b0;

    lat = 0; nrd = 0; nwr = 0; nboth = 0; nready = 0; nbadaddr = 0; nbadw = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (MemRead) begin
        nrd++;
        if (mem_address != 32'(base / 4)) nbadaddr++;
      end
      if (MemWrite) begin
        nwr++;
        if (mem_address != 32'(base / 4)) nbadaddr++;
        if (mem_write_data != wdata_exp) nbadw++;
      end
      if (MemRead && MemWrite) nboth++;
      if (req_ready) nready++;
      if (resp_valid) begin lat = cyc; break; end
      @(negedge clk);
    end

    check("latency",    32'(lat),      32'(lat_exp));
    check("resp_err",   32'(resp_err), 32'(e));
    check("resp_rdata", resp_rdata,    rdata_exp);
    check("memread_n",  32'(nrd),      32'(rd_exp));
    check("memwrite_n", 32'(nwr),      32'(wr_exp));
    check("strobe_both", 32'(nboth),   32'd0);
    check("ready_busy", 32'(nready),   32'd0);
    check("mem_addr",   32'(nbadaddr), 32'd0);
    check("mem_wdata",  32'(nbadw),    32'd0);
  endtask

  initial begin
    int seen;
    logic [1:0]  sz;
    logic [31:0] addr;
    int r;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_ready",  32'(req_ready),  32'd1);
    check("rst_valid",  32'(resp_valid), 32'd0);
    check("rst_rdata",  resp_rdata,      32'd0);
    check("rst_err",    32'(resp_err),   32'd0);
    check("rst_strobe", 32'({MemRead, MemWrite}), 32'd0);
    check("rst_addr",   mem_address,     32'd0);
    check("rst_wdata",  mem_write_data,  32'd0);
    rst = 1'b0;

    do_req(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b0);
    check("tp_lw", resp_rdata, 32'hDEADBEEF);
    do_req(1'b0, 2'd0, 1'b0, 32'h09, 32'h0, 1'b0);
    check("tp_lb", resp_rdata, 32'hFFFFFFBE);
    do_req(1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 1'b0);
    check("tp_lhu", resp_rdata, 32'h0000DEAD);
    do_req(1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, 1'b0);
    check("tp_lh", resp_rdata, 32'hFFFFDEAD);
    do_req(1'b1, 2'd0, 1'b0, 32'h0B, 32'h55, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h08, 32'h1234, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b0);
    check("tp_merge", resp_rdata, 32'h55AD1234);
    do_req(1'b0, 2'd1, 1'b0, 32'h03, 32'h0, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'h04, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 1'b0);
    // Valid held high across two requests: busy cycles must not accept.
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'hA5, 1'b1);
    do_req(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b0);

    // Reset during the write phase of a sub-word store.
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd0; req_addr = 32'h04; req_wdata = 32'hAA; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_wr", 32'(MemWrite), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready",  32'(req_ready),  32'd1);
    check("abort_valid",  32'(resp_valid), 32'd0);
    check("abort_strobe", 32'({MemRead, MemWrite}), 32'd0);
    check("abort_rdata",  resp_rdata,      32'd0);
    check("abort_err",    32'(resp_err),   32'd0);
    check("abort_addr",   mem_address,     32'd0);
    check("abort_wdata",  mem_write_data,  32'd0);
    rst = 1'b0;
    clear_model();
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("abort_no_resp", 32'(seen), 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 1'b0);
    check("abort_cleared", resp_rdata, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = 32'($urandom_range(0, 127));
      if (sz != 2'd0 && $urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr,
             $urandom, $urandom_range(0, 3) == 0);
    end

    req_valid = 1'b0;
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
